// File: rtl/eproc_in_frame_checker.sv
// ---------------------------------------------------------------------------
// eproc_in_frame_checker
//
// Back end of the e-link receive path. Takes decoded 8b10b symbols with their
// ISK flags, frames them on SOP/EOP delimiters, checks the payload against the
// incrementing byte pattern of the data generator and forwards the framed
// bytes to the RX FIFO write side. Saturating frame/error counters and sticky
// error flags feed the DCS status registers.
//
// Parameters
//   MAX_LEN  max payload bytes per frame; one more data byte is an overflow
//   CNT_W    width of frame_cnt / err_cnt (saturating)
//   CHK_PAT  1: each byte must equal previous byte + 1 (mod 256); 0: framing only
//
// Ports
//   bitCLK      in   clock, all logic on the rising edge
//   rst         in   asynchronous active-low reset
//   HGFEDCBA    in   decoded byte
//   ISK         in   00 data, 10 SOP, 01 EOP, 11 comma/idle
//   DATA_RDY    in   one-cycle strobe, HGFEDCBA/ISK valid
//   clr_cnt     in   synchronous clear of counters and sticky flags
//   dout        out  forwarded payload byte (8'h00 on the EOP write)
//   dout_sop    out  dout is the first byte of its frame
//   dout_eop    out  this write is the EOP marker of the frame
//   wr_en       out  one-cycle FIFO write strobe
//   frame_done  out  one-cycle pulse when a frame closes (EOP)
//   frame_ok    out  frame had no error, valid while frame_done=1
//   frame_cnt   out  good frames received
//   err_cnt     out  error events (one per DATA_RDY cycle raising an error)
//   byte_cnt    out  payload length of the current or last frame
//   err_sticky  out  [0] pattern [1] orphan EOP/data [2] SOP in frame [3] overflow
//   state_dbg   out  FSM state: 0 IDLE, 1 IN_FRAME, 2 DROP
//
// Handshake: the input side is a strobe-only interface (DATA_RDY acts as
// valid, there is no ready; every strobed symbol is consumed). The output side
// is likewise strobe-only: wr_en marks one FIFO write, the FIFO cannot stall
// this block. All outputs are registered and change only one clock after a
// DATA_RDY cycle (clr_cnt acts on the counters on any cycle).
// ---------------------------------------------------------------------------
module eproc_in_frame_checker #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16,
  parameter bit CHK_PAT = 1'b1
) (
  input  logic             bitCLK,
  input  logic             rst,
  input  logic [7:0]       HGFEDCBA,
  input  logic [1:0]       ISK,
  input  logic             DATA_RDY,
  input  logic             clr_cnt,
  output logic [7:0]       dout,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic             wr_en,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [8:0]       byte_cnt,
  output logic [3:0]       err_sticky,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DROP     = 2'd2
  } state_t;

  localparam logic [1:0] ISK_DATA  = 2'b00;
  localparam logic [1:0] ISK_EOP   = 2'b01;
  localparam logic [1:0] ISK_SOP   = 2'b10;
  localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered state
  state_t     state;
  logic       first_pending; // next data byte opens the frame
  logic       frame_bad;     // current frame has seen a pattern error
  logic [7:0] exp_byte;      // value the next payload byte must carry
  logic       orphan_run;    // inside a run of data symbols outside a frame

  // Next values
  state_t           state_nxt;
  logic             first_pending_nxt;
  logic             frame_bad_nxt;
  logic [7:0]       exp_byte_nxt;
  logic             orphan_run_nxt;
  logic [7:0]       dout_nxt;
  logic             dout_sop_nxt;
  logic             dout_eop_nxt;
  logic             wr_en_nxt;
  logic             frame_done_nxt;
  logic             frame_ok_nxt;
  logic [CNT_W-1:0] frame_cnt_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic [8:0]       byte_cnt_nxt;
  logic [3:0]       err_sticky_nxt;

  // Per-symbol events
  logic [3:0] err_set;     // sticky bits raised by this symbol
  logic       empty_err;   // empty frame: counted as an error, no sticky bit
  logic       good_frame;  // frame closed cleanly this symbol
  logic       is_data;
  logic       is_sop;
  logic       is_eop;

  assign is_data   = (ISK == ISK_DATA);
  assign is_sop    = (ISK == ISK_SOP);
  assign is_eop    = (ISK == ISK_EOP);
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge bitCLK or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      first_pending <= 1'b0;
      frame_bad     <= 1'b0;
      exp_byte      <= 8'h00;
      orphan_run    <= 1'b0;
      dout          <= 8'h00;
      dout_sop      <= 1'b0;
      dout_eop      <= 1'b0;
      wr_en         <= 1'b0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
      byte_cnt      <= 9'd0;
      err_sticky    <= 4'h0;
    end else begin
      state         <= state_nxt;
      first_pending <= first_pending_nxt;
      frame_bad     <= frame_bad_nxt;
      exp_byte      <= exp_byte_nxt;
      orphan_run    <= orphan_run_nxt;
      dout          <= dout_nxt;
      dout_sop      <= dout_sop_nxt;
      dout_eop      <= dout_eop_nxt;
      wr_en         <= wr_en_nxt;
      frame_done    <= frame_done_nxt;
      frame_ok      <= frame_ok_nxt;
      frame_cnt     <= frame_cnt_nxt;
      err_cnt       <= err_cnt_nxt;
      byte_cnt      <= byte_cnt_nxt;
      err_sticky    <= err_sticky_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt         = state;
    first_pending_nxt = first_pending;
    frame_bad_nxt     = frame_bad;
    exp_byte_nxt      = exp_byte;
    orphan_run_nxt    = orphan_run;
    dout_nxt          = dout;
    dout_sop_nxt      = dout_sop;
    dout_eop_nxt      = dout_eop;
    wr_en_nxt         = 1'b0;
    frame_done_nxt    = 1'b0;
    frame_ok_nxt      = frame_ok;
    byte_cnt_nxt      = byte_cnt;
    err_set           = 4'h0;
    empty_err         = 1'b0;
    good_frame        = 1'b0;

    // Commas (ISK=11) fall through every branch below and change nothing.
    if (DATA_RDY) begin
      unique case (state)
        IDLE: begin
          if (is_sop) begin
            state_nxt         = IN_FRAME;
            byte_cnt_nxt      = 9'd0;
            first_pending_nxt = 1'b1;
            frame_bad_nxt     = 1'b0;
            orphan_run_nxt    = 1'b0;
          end else if (is_eop) begin
            err_set[1]     = 1'b1;
            orphan_run_nxt = 1'b0;
          end else if (is_data) begin
            // Only the first data symbol of a stray run is an error event.
            err_set[1]     = !orphan_run;
            orphan_run_nxt = 1'b1;
          end
        end

        IN_FRAME: begin
          if (is_data) begin
            if (byte_cnt == MAX_LEN_C) begin
              // Frame too long: this byte is discarded and so is the rest.
              err_set[3] = 1'b1;
              state_nxt  = DROP;
            end else begin
              wr_en_nxt         = 1'b1;
              dout_nxt          = HGFEDCBA;
              dout_sop_nxt      = first_pending;
              dout_eop_nxt      = 1'b0;
              first_pending_nxt = 1'b0;
              byte_cnt_nxt      = byte_cnt + 9'd1;
              exp_byte_nxt      = HGFEDCBA + 8'd1;
              if (CHK_PAT && !first_pending && (HGFEDCBA != exp_byte)) begin
                err_set[0]    = 1'b1;
                frame_bad_nxt = 1'b1;
              end
            end
          end else if (is_eop) begin
            wr_en_nxt      = 1'b1;
            dout_nxt       = 8'h00;
            dout_sop_nxt   = 1'b0;
            dout_eop_nxt   = 1'b1;
            frame_done_nxt = 1'b1;
            good_frame     = !frame_bad && (byte_cnt != 9'd0);
            frame_ok_nxt   = good_frame;
            empty_err      = (byte_cnt == 9'd0);
            state_nxt      = IDLE;
          end else if (is_sop) begin
            // Unterminated frame is abandoned; the new SOP starts afresh.
            err_set[2]        = 1'b1;
            byte_cnt_nxt      = 9'd0;
            first_pending_nxt = 1'b1;
            frame_bad_nxt     = 1'b0;
          end
        end

        DROP: begin
          if (is_eop) begin
            frame_done_nxt = 1'b1;
            frame_ok_nxt   = 1'b0;
            state_nxt      = IDLE;
          end else if (is_sop) begin
            state_nxt         = IN_FRAME;
            byte_cnt_nxt      = 9'd0;
            first_pending_nxt = 1'b1;
            frame_bad_nxt     = 1'b0;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Counters: clear has priority over any increment in the same cycle.
    if (clr_cnt) begin
      frame_cnt_nxt  = '0;
      err_cnt_nxt    = '0;
      err_sticky_nxt = 4'h0;
    end else begin
      frame_cnt_nxt  = frame_cnt;
      err_cnt_nxt    = err_cnt;
      err_sticky_nxt = err_sticky | err_set;
      if (good_frame && (frame_cnt != CNT_MAX)) begin
        frame_cnt_nxt = frame_cnt + CNT_ONE;
      end
      if (((err_set != 4'h0) || empty_err) && (err_cnt != CNT_MAX)) begin
        err_cnt_nxt = err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_eproc_in_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_eproc_in_frame_checker
//
// Two instances share one symbol stream: u_big with default parameters and
// u_small with MAX_LEN=4, CNT_W=2 so overflow and counter saturation are
// reached quickly. A frame-level reference model tracks each instance and is
// compared against every output one step after each symbol. Written bytes of
// u_big are also scoreboarded through an expected queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eproc_in_frame_checker;

  // -------------------------------------------------------------------------
  // Clock / reset / stimulus signals
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] HGFEDCBA = 8'h00;
  logic [1:0] ISK = 2'b11;
  logic       DATA_RDY = 1'b0;
  logic       clr_cnt = 1'b0;

  always #12 clk = ~clk;

  localparam logic [1:0] K_DATA  = 2'b00;
  localparam logic [1:0] K_EOP   = 2'b01;
  localparam logic [1:0] K_SOP   = 2'b10;
  localparam logic [1:0] K_COMMA = 2'b11;

  // u_big outputs
  logic [7:0]  b_dout;
  logic        b_sop, b_eop, b_wr, b_fd, b_fok;
  logic [15:0] b_fc, b_ec;
  logic [8:0]  b_bc;
  logic [3:0]  b_st;
  logic [1:0]  b_sd;

  // u_small outputs
  logic [7:0]  s_dout;
  logic        s_sop, s_eop, s_wr, s_fd, s_fok;
  logic [1:0]  s_fc, s_ec;
  logic [8:0]  s_bc;
  logic [3:0]  s_st;
  logic [1:0]  s_sd;

  eproc_in_frame_checker u_big (
    .bitCLK(clk), .rst(rst), .HGFEDCBA(HGFEDCBA), .ISK(ISK), .DATA_RDY(DATA_RDY),
    .clr_cnt(clr_cnt), .dout(b_dout), .dout_sop(b_sop), .dout_eop(b_eop),
    .wr_en(b_wr), .frame_done(b_fd), .frame_ok(b_fok), .frame_cnt(b_fc),
    .err_cnt(b_ec), .byte_cnt(b_bc), .err_sticky(b_st), .state_dbg(b_sd)
  );

  eproc_in_frame_checker #(.MAX_LEN(4), .CNT_W(2), .CHK_PAT(1'b1)) u_small (
    .bitCLK(clk), .rst(rst), .HGFEDCBA(HGFEDCBA), .ISK(ISK), .DATA_RDY(DATA_RDY),
    .clr_cnt(clr_cnt), .dout(s_dout), .dout_sop(s_sop), .dout_eop(s_eop),
    .wr_en(s_wr), .frame_done(s_fd), .frame_ok(s_fok), .frame_cnt(s_fc),
    .err_cnt(s_ec), .byte_cnt(s_bc), .err_sticky(s_st), .state_dbg(s_sd)
  );

  // -------------------------------------------------------------------------
  // Reference model: one frame-level view per instance
  // mode: 0 waiting for SOP, 1 collecting payload, 2 discarding after overflow
  // -------------------------------------------------------------------------
  typedef struct {
    int         mode;
    int         len;
    logic [7:0] last;
    bit         bad;
    bit         run;
    int         fcnt;
    int         ecnt;
    logic [3:0] sticky;
    bit         wr;
    logic [7:0] dout;
    bit         sop;
    bit         eop;
    bit         fd;
    bit         fok;
  } mdl_t;

  mdl_t m [2];
  int   max_len [2];
  int   cnt_max [2];
  int   dwr_cnt [2];   // data (non-EOP) writes observed per instance

  logic [9:0] exp_q[$]; // {sop, eop, dout} expected on u_big writes

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.mode = 0; z.len = 0; z.last = 8'h00; z.bad = 1'b0; z.run = 1'b0;
    z.fcnt = 0; z.ecnt = 0; z.sticky = 4'h0; z.wr = 1'b0; z.dout = 8'h00;
    z.sop = 1'b0; z.eop = 1'b0; z.fd = 1'b0; z.fok = 1'b0;
    return z;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int ml, input int cm,
                                    input bit rdy, input logic [1:0] isk,
                                    input logic [7:0] b, input bit clr);
    mdl_t       n = s;
    logic [3:0] e = 4'h0;
    bit         counted = 1'b0;
    n.wr = 1'b0;
    n.fd = 1'b0;
    if (rdy && isk != K_COMMA) begin
      if (s.mode == 0) begin
        if (isk == K_SOP) begin
          n.mode = 1; n.len = 0; n.bad = 1'b0; n.run = 1'b0;
        end else if (isk == K_EOP) begin
          e[1] = 1'b1; n.run = 1'b0;
        end else begin
          if (!s.run) e[1] = 1'b1;
          n.run = 1'b1;
        end
      end else if (s.mode == 1) begin
        if (isk == K_DATA) begin
          if (s.len == ml) begin
            e[3] = 1'b1; n.mode = 2;
          end else begin
            n.wr = 1'b1; n.dout = b; n.sop = (s.len == 0); n.eop = 1'b0;
            if (s.len > 0 && int'(b) != (int'(s.last) + 1) % 256) begin
              e[0] = 1'b1; n.bad = 1'b1;
            end
            n.last = b;
            n.len  = s.len + 1;
          end
        end else if (isk == K_EOP) begin
          n.wr = 1'b1; n.dout = 8'h00; n.sop = 1'b0; n.eop = 1'b1;
          n.fd = 1'b1; n.fok = !s.bad && s.len > 0;
          if (n.fok && s.fcnt < cm) n.fcnt = s.fcnt + 1;
          if (s.len == 0) counted = 1'b1;
          n.mode = 0;
        end else begin
          e[2] = 1'b1; n.len = 0; n.bad = 1'b0;
        end
      end else begin
        if (isk == K_EOP) begin
          n.fd = 1'b1; n.fok = 1'b0; n.mode = 0;
        end else if (isk == K_SOP) begin
          n.mode = 1; n.len = 0; n.bad = 1'b0;
        end
      end
    end
    if ((e != 4'h0 || counted) && n.ecnt < cm) n.ecnt = n.ecnt + 1;
    n.sticky = n.sticky | e;
    if (clr) begin
      n.fcnt = 0; n.ecnt = 0; n.sticky = 4'h0;
    end
    return n;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [9:0] w;
    // u_big
    chk("big.state", 32'(b_sd), 32'(m[0].mode));
    chk("big.wr_en", 32'(b_wr), 32'(m[0].wr));
    if (b_wr) begin
      if (!b_eop) dwr_cnt[0]++;
      chk("big.wr_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("big.wr_word", {22'd0, b_sop, b_eop, b_dout}, {22'd0, w});
      end
    end
    chk("big.frame_done", 32'(b_fd), 32'(m[0].fd));
    if (m[0].fd) chk("big.frame_ok", 32'(b_fok), 32'(m[0].fok));
    chk("big.frame_cnt", 32'(b_fc), 32'(m[0].fcnt));
    chk("big.err_cnt", 32'(b_ec), 32'(m[0].ecnt));
    chk("big.byte_cnt", 32'(b_bc), 32'(m[0].len));
    chk("big.err_sticky", 32'(b_st), 32'(m[0].sticky));
    // u_small
    chk("small.state", 32'(s_sd), 32'(m[1].mode));
    chk("small.wr_en", 32'(s_wr), 32'(m[1].wr));
    if (s_wr && !s_eop) dwr_cnt[1]++;
    if (m[1].wr) begin
      chk("small.dout", 32'(s_dout), 32'(m[1].dout));
      chk("small.dout_sop", 32'(s_sop), 32'(m[1].sop));
      chk("small.dout_eop", 32'(s_eop), 32'(m[1].eop));
    end
    chk("small.frame_done", 32'(s_fd), 32'(m[1].fd));
    if (m[1].fd) chk("small.frame_ok", 32'(s_fok), 32'(m[1].fok));
    chk("small.frame_cnt", 32'(s_fc), 32'(m[1].fcnt));
    chk("small.err_cnt", 32'(s_ec), 32'(m[1].ecnt));
    chk("small.byte_cnt", 32'(s_bc), 32'(m[1].len));
    chk("small.err_sticky", 32'(s_st), 32'(m[1].sticky));
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // One clock: present a symbol (or nothing), advance the models, check.
  task automatic step(input logic [1:0] isk, input logic [7:0] b, input bit rdy, input bit clr);
    ISK      = isk;
    HGFEDCBA = b;
    DATA_RDY = rdy;
    clr_cnt  = clr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m[i] = mdl_step(m[i], max_len[i], cnt_max[i], rdy, isk, b, clr);
    end
    if (m[0].wr) exp_q.push_back({m[0].sop, m[0].eop, m[0].dout});
    #1;
    compare_all();
    DATA_RDY = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic sym(input logic [1:0] isk, input logic [7:0] b);
    step(isk, b, 1'b1, 1'b0);
  endtask

  task automatic clear_counts();
    step(K_COMMA, 8'h00, 1'b0, 1'b1);
    dwr_cnt[0] = 0;
    dwr_cnt[1] = 0;
  endtask

  task automatic send_frame(input logic [7:0] start, input int len);
    logic [7:0] v;
    v = start;
    sym(K_SOP, 8'h00);
    for (int j = 0; j < len; j++) begin
      sym(K_DATA, v);
      v = v + 8'd1;
    end
    sym(K_EOP, 8'h00);
  endtask

  task automatic noise();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) sym(K_COMMA, 8'(($urandom_range(0, 255))));
    else if (r < 3) step(K_DATA, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst.big.dout", 32'(b_dout), 32'd0);
    chk("rst.big.sop_eop_ok", {29'd0, b_sop, b_eop, b_fok}, 32'd0);
    chk("rst.small.dout", 32'(s_dout), 32'd0);
    chk("rst.small.sop_eop_ok", {29'd0, s_sop, s_eop, s_fok}, 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed and random sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [7:0] v;
    int         len;
    max_len[0] = 256; cnt_max[0] = 65535;
    max_len[1] = 4;   cnt_max[1] = 3;
    m[0] = mdl_zero();
    m[1] = mdl_zero();
    dwr_cnt[0] = 0;
    dwr_cnt[1] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // T1: plain 10-byte frame
    clear_counts();
    send_frame(8'h00, 10);
    chk("t1.data_writes", 32'(dwr_cnt[0]), 32'd10);
    chk("t1.frame_ok", 32'(b_fok), 32'd1);
    chk("t1.frame_cnt", 32'(b_fc), 32'd1);
    chk("t1.err_cnt", 32'(b_ec), 32'd0);
    chk("t1.byte_cnt", 32'(b_bc), 32'd10);

    // T2: pattern wraps FF -> 00
    clear_counts();
    send_frame(8'hFE, 4);
    chk("t2.frame_ok", 32'(b_fok), 32'd1);
    chk("t2.frame_cnt", 32'(b_fc), 32'd1);
    chk("t2.err_cnt", 32'(b_ec), 32'd0);

    // T3: pattern break
    clear_counts();
    sym(K_SOP, 8'h00);
    sym(K_DATA, 8'h00); sym(K_DATA, 8'h01); sym(K_DATA, 8'h05); sym(K_DATA, 8'h06);
    sym(K_EOP, 8'h00);
    chk("t3.err_sticky", 32'(b_st), 32'h1);
    chk("t3.err_cnt", 32'(b_ec), 32'd1);
    chk("t3.frame_ok", 32'(b_fok), 32'd0);
    chk("t3.frame_cnt", 32'(b_fc), 32'd0);

    // T4: orphan EOP, then SOP inside a frame
    clear_counts();
    sym(K_EOP, 8'h00);
    sym(K_SOP, 8'h00); sym(K_DATA, 8'h00);
    sym(K_SOP, 8'h00); sym(K_DATA, 8'h00); sym(K_DATA, 8'h01);
    sym(K_EOP, 8'h00);
    chk("t4.err_sticky", 32'(b_st), 32'h6);
    chk("t4.err_cnt", 32'(b_ec), 32'd2);
    chk("t4.frame_cnt", 32'(b_fc), 32'd1);

    // T5: overflow on the MAX_LEN=4 instance
    clear_counts();
    send_frame(8'h00, 6);
    chk("t5.small.data_writes", 32'(dwr_cnt[1]), 32'd4);
    chk("t5.small.err_sticky3", 32'(s_st[3]), 32'd1);
    chk("t5.small.frame_ok", 32'(s_fok), 32'd0);
    chk("t5.small.err_cnt", 32'(s_ec), 32'd1);
    chk("t5.small.byte_cnt", 32'(s_bc), 32'd4);

    // Empty frame and orphan data run
    clear_counts();
    send_frame(8'h00, 0);
    chk("empty.frame_ok", 32'(b_fok), 32'd0);
    chk("empty.err_cnt", 32'(b_ec), 32'd1);
    sym(K_DATA, 8'h11); sym(K_COMMA, 8'h00); sym(K_DATA, 8'h12); sym(K_DATA, 8'h13);
    chk("orphan_run.err_cnt", 32'(b_ec), 32'd2);

    // T6: reset mid-frame
    clear_counts();
    sym(K_SOP, 8'h00); sym(K_DATA, 8'h00); sym(K_DATA, 8'h01); sym(K_DATA, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    #1;
    m[0] = mdl_zero();
    m[1] = mdl_zero();
    exp_q.delete();
    compare_all();
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    send_frame(8'h00, 1);
    chk("t6.frame_ok", 32'(b_fok), 32'd1);
    chk("t6.frame_cnt", 32'(b_fc), 32'd1);

    // T7: T1 with commas, gaps and clr_cnt on the EOP
    clear_counts();
    sym(K_SOP, 8'h00);
    for (int j = 0; j < 10; j++) begin
      if (j % 3 == 0) sym(K_COMMA, 8'hBC);
      if (j % 4 == 1) step(K_DATA, 8'h55, 1'b0, 1'b0);
      sym(K_DATA, 8'(j));
    end
    step(K_EOP, 8'h00, 1'b1, 1'b1);
    chk("t7.data_writes", 32'(dwr_cnt[0]), 32'd10);
    chk("t7.frame_ok", 32'(b_fok), 32'd1);
    chk("t7.frame_cnt", 32'(b_fc), 32'd0);
    chk("t7.err_cnt", 32'(b_ec), 32'd0);
    chk("t7.byte_cnt", 32'(b_bc), 32'd10);

    // Random frames against the model
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: sym(K_DATA, 8'($urandom_range(0, 255)));
          1: sym(K_EOP, 8'h00);
          default: sym(K_SOP, 8'h00);
        endcase
      end
      sym(K_SOP, 8'h00);
      len = $urandom_range(0, 8);
      v   = 8'($urandom_range(0, 255));
      for (int j = 0; j < len; j++) begin
        noise();
        if ($urandom_range(0, 11) == 0) sym(K_DATA, v ^ 8'($urandom_range(1, 255)));
        else sym(K_DATA, v);
        v = v + 8'd1;
      end
      noise();
      if ($urandom_range(0, 9) != 0) step(K_EOP, 8'h00, 1'b1, ($urandom_range(0, 29) == 0));
    end
    sym(K_EOP, 8'h00);

    chk("big.wr_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
